uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_if.sv | 16 +
 rtl/uart_baud_tick.sv | 27 ++
 rtl/uart_rx.sv | 170 +++++++++++++++++
 tb/tb_uart_rx.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and helpers: receiver state encoding, majority-vote sample offsets,
// and the clock divider calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  // The three vote samples are taken at mid-MAJ_PRE, mid, and mid+MAJ_POST of each bit.
  localparam int unsigned MAJ_PRE  = 1;
  localparam int unsigned MAJ_POST = 1;

  function automatic int calc_div(input longint clk_freq, input longint baud,
                                  input longint oversample);
    return int'(clk_freq / (baud * oversample));
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// FIFO-side port of the UART receiver: write strobe/data, status pulses, and the full flag.
// Handshake: DATAo is only meaningful while WEo=1. Each WEo pulse lasts one cycle and means
// "write now"; no back-pressure exists beyond FULLi, which is read once per frame.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] DATAo;
  logic                  WEo;
  logic                  FERRo;
  logic                  OVRo;
  logic                  PERRo;
  logic                  FULLi;

  modport master (output DATAo, WEo, FERRo, OVRo, PERRo, input FULLi);
  modport slave  (input DATAo, WEo, FERRo, OVRo, PERRo, output FULLi);
endinterface

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: counts 0..DIV-1 and pulses tick on the last count.
// A synchronous clear lets the user re-phase the tick to an external event.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic CLKip,
  input  logic RSTni,
  input  logic clr,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLKip or negedge RSTni) begin
    if (!RSTni) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);
endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 by default, 8E1/8O1 when UART_RX_PARITY_EN is defined.
// Oversamples RXi, votes three mid-bit samples, and drives the FIFO write port directly.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 16_000_000,
  parameter int BAUD       = 1_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_WIDTH = 8,
`ifdef UART_RX_PARITY_EN
  parameter bit PARITY_ODD = 1'b0,
`endif
  parameter int DIV        = calc_div(CLK_FREQ, BAUD, OVERSAMPLE)
) (
  input  logic       CLKip,
  input  logic       RSTni,
  input  logic       RXi,
  uart_rx_if.master  fifo,
  output logic       BUSYo,
  output rx_state_t  state_dbg
);
  if (DIV < 1) begin : g_bad_div
    $error("uart_rx: DIV must be at least 1");
  end
  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("uart_rx: OVERSAMPLE must be even and at least 8");
  end

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [SW-1:0] S_LO   = SW'(OVERSAMPLE / 2 - MAJ_PRE);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_HI   = SW'(OVERSAMPLE / 2 + MAJ_POST);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

  rx_state_t             state;
  logic [1:0]            sync;
  logic                  rx_s;
  logic [SW-1:0]         scnt;
  logic [BW-1:0]         bcnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  v_lo, v_mid, vote, armed;
  logic                  we_q, ferr_q, ovr_q;
  logic                  tick, clr;
  logic                  at_lo, at_mid, at_vote, at_wrap;
`ifdef UART_RX_PARITY_EN
  logic                  par_bit, perr_q;
`endif

  assign rx_s    = sync[1];
  assign clr     = (state == IDLE) && !rx_s && armed;
  assign at_lo   = tick && (scnt == S_LO);
  assign at_mid  = tick && (scnt == S_MID);
  assign at_vote = tick && (scnt == S_HI);
  assign at_wrap = tick && (scnt == S_LAST);
  assign vote    = (v_lo & v_mid) | (v_lo & rx_s) | (v_mid & rx_s);

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .CLKip (CLKip),
    .RSTni (RSTni),
    .clr   (clr),
    .tick  (tick)
  );

  always_ff @(posedge CLKip or negedge RSTni) begin
    if (!RSTni) begin
      sync   <= 2'b11;
      state  <= IDLE;
      scnt   <= '0;
      bcnt   <= '0;
      shreg  <= '0;
      data_q <= '0;
      v_lo   <= 1'b1;
      v_mid  <= 1'b1;
      armed  <= 1'b0;
      we_q   <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      sync   <= {sync[0], RXi};
      we_q   <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q <= 1'b0;
`endif
      if (rx_s) armed <= 1'b1;
      if (at_lo) v_lo <= rx_s;
      if (at_mid) v_mid <= rx_s;
      if (tick && state != IDLE) scnt <= (scnt == S_LAST) ? '0 : scnt + 1'b1;

      case (state)
        IDLE: begin
          if (clr) begin
            state <= START;
            scnt  <= '0;
          end
        end
        START: begin
          if (at_vote && vote) begin
            state <= IDLE;
          end else if (at_wrap) begin
            state <= DATA;
            bcnt  <= '0;
          end
        end
        DATA: begin
          if (at_vote) shreg <= {vote, shreg[DATA_WIDTH-1:1]};
          if (at_wrap) begin
            if (bcnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (at_vote) par_bit <= vote;
          if (at_wrap) state <= STOP;
        end
`endif
        STOP: begin
          // Decide at the vote point and leave at once so a back-to-back start bit is seen.
          if (at_vote) begin
            state <= IDLE;
            if (!vote) begin
              ferr_q <= 1'b1;
              armed  <= 1'b0;
            end
`ifdef UART_RX_PARITY_EN
            else if (par_bit != ((^shreg) ^ PARITY_ODD)) begin
              perr_q <= 1'b1;
            end
`endif
            else if (fifo.FULLi) begin
              ovr_q <= 1'b1;
            end else begin
              we_q   <= 1'b1;
              data_q <= shreg;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fifo.DATAo = data_q;
  assign fifo.WEo   = we_q;
  assign fifo.FERRo = ferr_q;
  assign fifo.OVRo  = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign fifo.PERRo = perr_q;
`else
  assign fifo.PERRo = 1'b0;
`endif
  assign BUSYo      = (state != IDLE);
  assign state_dbg  = state;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at DIV=1 (16 clocks per bit): directed plan plus random frames
// scored against a frame-level outcome model.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BIT_CLKS = 16;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  logic      rx = 1'b1;
  logic      busy;
  rx_state_t state_dbg;
  int        cyc = 0;
  int        checks = 0;
  int        errors = 0;

  uart_rx_if #(.DATA_WIDTH(8)) fifo_if ();

  uart_rx #(
    .CLK_FREQ   (16_000_000),
    .BAUD       (1_000_000),
    .OVERSAMPLE (16),
    .DATA_WIDTH (8)
  ) dut (
    .CLKip     (clk),
    .RSTni     (rst_n),
    .RXi       (rx),
    .fifo      (fifo_if),
    .BUSYo     (busy),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state: expected bytes and expected totals of each pulse kind.
  logic [7:0] exp_q[$];
  int         we_times[$];
  int         we_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0;
  int         exp_we = 0, exp_ferr = 0, exp_ovr = 0, exp_perr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_if.WEo) begin
        we_cnt++;
        we_times.push_back(cyc);
        if (exp_q.size() == 0) check("we_unexpected", 32'd1, 32'd0);
        else check("we_data", 32'(fifo_if.DATAo), 32'(exp_q.pop_front()));
      end
      if (fifo_if.FERRo) ferr_cnt++;
      if (fifo_if.OVRo)  ovr_cnt++;
      if (fifo_if.PERRo) perr_cnt++;
    end
  end

  // Frame-level model: a bad stop bit wins, then bad parity, then a full FIFO, else a write.
  function automatic void predict(input logic [7:0] b, input bit stop_v, input bit par_bad,
                                  input bit full);
    if (!stop_v)       exp_ferr++;
    else if (par_bad)  exp_perr++;
    else if (full) exp_ovr++;
    else begin
      exp_we++;
      exp_q.push_back(b);
    end
  endfunction

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_v, input bit par_flip,
                            input int gap_bits);
    bit par_bad;
    par_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad = par_flip;
`endif
    predict(b, stop_v, par_bad, fifo_if.FULLi);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`else
    if (par_flip) rx = 1'b1;
`endif
    drive_bit(stop_v);
    if (gap_bits > 0) begin
      rx = 1'b1;
      repeat (gap_bits * BIT_CLKS) @(negedge clk);
    end
  endtask

  task automatic step_check(input string tag);
    repeat (20) @(negedge clk);
    check({tag, "_we"},   32'(we_cnt),   32'(exp_we));
    check({tag, "_ferr"}, 32'(ferr_cnt), 32'(exp_ferr));
    check({tag, "_ovr"},  32'(ovr_cnt),  32'(exp_ovr));
    check({tag, "_perr"}, 32'(perr_cnt), 32'(exp_perr));
    check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int t0, n0, d;
    logic [7:0] b;
    bit stop_v, full;
    fifo_if.FULLi = 1'b0;

    // Reset values while reset is held.
    repeat (3) @(negedge clk);
    check("rst_data", 32'(fifo_if.DATAo), 32'h0);
    check("rst_we",   32'(fifo_if.WEo),   32'h0);
    check("rst_ferr", 32'(fifo_if.FERRo), 32'h0);
    check("rst_ovr",  32'(fifo_if.OVRo),  32'h0);
    check("rst_perr", 32'(fifo_if.PERRo), 32'h0);
    check("rst_busy", 32'(busy),          32'h0);
    rst_n = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);

    // Single good frame and its latency from the falling edge.
    t0 = cyc;
    n0 = we_times.size();
    send_frame(8'hA5, 1'b1, 1'b0, 1);
    step_check("a5");
    if (we_times.size() > n0) begin
      d = we_times[n0] - t0;
      check("a5_latency_ok", 32'(d >= 150 && d <= 165), 32'd1);
    end else check("a5_latency_seen", 32'd0, 32'd1);

    // Back-to-back frames with no idle gap.
    n0 = we_times.size();
    send_frame(8'h3C, 1'b1, 1'b0, 0);
    send_frame(8'hC3, 1'b1, 1'b0, 1);
    step_check("b2b");
    if (we_times.size() >= n0 + 2) begin
      d = we_times[n0 + 1] - we_times[n0];
      check("b2b_spacing_ok", 32'(d >= 158 && d <= 162), 32'd1);
    end else check("b2b_pulses_seen", 32'(we_times.size() - n0), 32'd2);

    // Short glitch on an idle line is rejected, then a real frame.
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    step_check("glitch");
    send_frame(8'h55, 1'b1, 1'b0, 1);
    step_check("g55");

    // Framing error followed by a long break: one FERRo only.
    send_frame(8'h0F, 1'b0, 1'b0, 0);
    rx = 1'b0;
    repeat (40 * BIT_CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    step_check("break");
    send_frame(8'h81, 1'b1, 1'b0, 1);
    step_check("b81");

    // Overrun when the FIFO is full at the stop decision.
    fifo_if.FULLi = 1'b1;
    send_frame(8'h77, 1'b1, 1'b0, 1);
    fifo_if.FULLi = 1'b0;
    send_frame(8'h78, 1'b1, 1'b0, 1);
    step_check("ovr");

    // Reset at data bit 4 aborts the frame.
    b = 8'h99;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rx = 1'b1;
    rst_n = 1'b1;
    repeat (12 * BIT_CLKS) @(negedge clk);
    step_check("abort");
    send_frame(8'h99, 1'b1, 1'b0, 1);
    step_check("r99");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h01, 1'b1, 1'b1, 1);
    step_check("perr");
`endif

    // Random frames: random data, gaps, full flag, and occasional bad stop bits.
    for (int k = 0; k < 12; k++) begin
      b = 8'($urandom_range(0, 255));
      stop_v = ($urandom_range(0, 7) != 0);
      full = ($urandom_range(0, 3) == 0);
      fifo_if.FULLi = full;
      send_frame(b, stop_v, 1'b0, stop_v ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 3)));
    end
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    fifo_if.FULLi = 1'b0;
    step_check("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
